// File: rtl/led_indicator_mc_pkg.sv
// Shared definitions for the multi-channel LED indicator: mode encoding,
// channel FSM states and reset-time defaults.
package led_indicator_mc_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    localparam logic [3:0] DEF_BURST = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        ON_PH,
        OFF_PH,
        GAP
    } chanState_t;

    // Reset on/off time is half a second, gap is one second, in ticks.
    function automatic int unsigned defOnTicks(input int unsigned tickHz);
        return tickHz / 2;
    endfunction

    function automatic int unsigned defGapTicks(input int unsigned tickHz);
        return tickHz;
    endfunction

endpackage

// File: rtl/led_chan_fsm.sv
// One LED channel: latched config, phase FSM with tick and pulse counters,
// and a registered polarity-adjusted LED output.
module led_chan_fsm
    import led_indicator_mc_pkg::*;
#(
    parameter int unsigned TW      = 16,
    parameter logic        POL     = 1'b0,
    parameter int unsigned DEF_ON  = 500,
    parameter int unsigned DEF_GAP = 1000
) (
    input  logic          iClk,
    input  logic          iRst_N,
    input  logic          iTick,
    input  logic          iWr,
    input  logic          iSync,
    input  logic [1:0]    iMode,
    input  logic [TW-1:0] iOn,
    input  logic [TW-1:0] iOff,
    input  logic [TW-1:0] iGap,
    input  logic [3:0]    iBurst,
    output logic          oLed
);

    logic [1:0]    modeQ, modeD;
    logic [TW-1:0] onQ, onD, offQ, offD, gapQ, gapD;
    logic [3:0]    burstQ, burstD;
    chanState_t    stateQ, stateD;
    logic [TW-1:0] tickCntQ, tickCntD;
    logic [3:0]    pulseQ, pulseD;
    logic          ledQ, ledD;

    logic [TW-1:0] phaseField, phaseLen;
    logic          phaseDone;

    always_comb begin
        unique case (stateQ)
            ON_PH:   phaseField = onQ;
            OFF_PH:  phaseField = offQ;
            GAP:     phaseField = gapQ;
            default: phaseField = TW'(1);
        endcase
    end

    // A zero-length field still lasts one tick.
    assign phaseLen  = (phaseField == '0) ? TW'(1) : phaseField;
    assign phaseDone = (tickCntQ >= phaseLen - TW'(1));

    always_comb begin
        modeD    = modeQ;
        onD      = onQ;
        offD     = offQ;
        gapD     = gapQ;
        burstD   = burstQ;
        stateD   = stateQ;
        tickCntD = tickCntQ;
        pulseD   = pulseQ;
        if (iWr) begin
            modeD  = iMode;
            onD    = iOn;
            offD   = iOff;
            gapD   = iGap;
            burstD = iBurst;
        end
        // Restart takes priority over a coincident tick.
        if (iWr || iSync) begin
            stateD   = (modeD == MODE_BLINK || modeD == MODE_BURST) ? ON_PH : IDLE;
            tickCntD = '0;
            pulseD   = '0;
        end else if (modeQ == MODE_OFF || modeQ == MODE_ON) begin
            stateD   = IDLE;
            tickCntD = '0;
            pulseD   = '0;
        end else if (iTick) begin
            if (!phaseDone) begin
                tickCntD = tickCntQ + TW'(1);
            end else begin
                tickCntD = '0;
                unique case (stateQ)
                    ON_PH: stateD = OFF_PH;
                    OFF_PH: begin
                        if (modeQ == MODE_BURST && burstQ != 4'd0) begin
                            if (pulseQ >= burstQ - 4'd1) begin
                                stateD = GAP;
                                pulseD = '0;
                            end else begin
                                stateD = ON_PH;
                                pulseD = pulseQ + 4'd1;
                            end
                        end else begin
                            stateD = ON_PH;
                        end
                    end
                    default: stateD = ON_PH;
                endcase
            end
        end
        ledD = ((stateD == ON_PH) || (modeD == MODE_ON)) ^ POL;
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            modeQ    <= MODE_BLINK;
            onQ      <= TW'(DEF_ON);
            offQ     <= TW'(DEF_ON);
            gapQ     <= TW'(DEF_GAP);
            burstQ   <= DEF_BURST;
            stateQ   <= ON_PH;
            tickCntQ <= '0;
            pulseQ   <= '0;
            ledQ     <= POL;
        end else begin
            modeQ    <= modeD;
            onQ      <= onD;
            offQ     <= offD;
            gapQ     <= gapD;
            burstQ   <= burstD;
            stateQ   <= stateD;
            tickCntQ <= tickCntD;
            pulseQ   <= pulseD;
            ledQ     <= ledD;
        end
    end

    assign oLed = ledQ;

endmodule

// File: rtl/led_indicator_mc.sv
// Multi-channel LED indicator: shared tick prescaler, IO-mux toggle and
// NUM_CH independent blink/burst channels.
module led_indicator_mc
    import led_indicator_mc_pkg::*;
#(
    parameter int unsigned        NUM_CH  = 2,
    parameter int unsigned        CLK_HZ  = 100_000_000,
    parameter int unsigned        TICK_HZ = 1000,
    parameter int unsigned        TW      = 16,
    parameter logic [NUM_CH-1:0]  LED_POL = '0,
    localparam int unsigned       CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              iClk,
    input  logic              iRst_N,
    input  logic              iCfgWr,
    input  logic [CH_W-1:0]   iCfgCh,
    input  logic [1:0]        iCfgMode,
    input  logic [TW-1:0]     iCfgOn,
    input  logic [TW-1:0]     iCfgOff,
    input  logic [TW-1:0]     iCfgGap,
    input  logic [3:0]        iCfgBurst,
    input  logic              iSync,
    output logic [NUM_CH-1:0] oLED,
    output logic              oIOMux,
    output logic              oTick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] prescQ, prescD;
    logic          tick;
    logic          ioMuxQ;

    assign tick = (prescQ == PW'(DIV - 1));

    always_comb begin
        prescD = prescQ + PW'(1);
        if (iSync || tick) begin
            prescD = '0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            prescQ <= '0;
            ioMuxQ <= 1'b0;
        end else begin
            prescQ <= prescD;
            ioMuxQ <= ~ioMuxQ;
        end
    end

    assign oTick  = tick;
    assign oIOMux = ioMuxQ;

    // Out-of-range channel numbers match no instance, so the write is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        led_chan_fsm #(
            .TW      (TW),
            .POL     (LED_POL[i]),
            .DEF_ON  (defOnTicks(TICK_HZ)),
            .DEF_GAP (defGapTicks(TICK_HZ))
        ) uChan (
            .iClk   (iClk),
            .iRst_N (iRst_N),
            .iTick  (tick),
            .iWr    (iCfgWr && (iCfgCh == CH_W'(i))),
            .iSync  (iSync),
            .iMode  (iCfgMode),
            .iOn    (iCfgOn),
            .iOff   (iCfgOff),
            .iGap   (iCfgGap),
            .iBurst (iCfgBurst),
            .oLed   (oLED[i])
        );
    end

endmodule
